// File: rtl/serial_rom_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_rom_bank
// Purpose  : Bit-serial, multi-page instruction ROM for the HP classic CPU
//            replica. It receives the word address serially and fetches one
//            instruction per word from the page array. It shifts that
//            instruction back out serially, and it decodes page-select and
//            word-select instructions.
// Ports    : cph2      - clock, all state changes on its rising edge
//            pon       - synchronous active-high reset
//            sync      - word sync; its falling edge marks word start
//            ia        - serial address in, LSB first
//            lpmode    - low-power mode; the fetch returns a NOP
//            is        - serial instruction out, LSB first (+ status marker)
//            ws        - word-select window for the current word
//            page_cur  - active ROM page
//            page_err  - sticky flag, a select named a nonexistent page
// Array    : ROM_INIT is the packed array image. Word k = {page, adr} sits at
//            bits [k*INST_W +: INST_W].
// Revision : 1.0 - initial release
// ============================================================================
module serial_rom_bank #(
  parameter int DIGITS  = 14,
  parameter int ADR_W   = 8,
  parameter int INST_W  = 10,
  parameter int N_PAGES = 4,
  parameter int PAGE_W  = 3,
  parameter logic [N_PAGES*(2**ADR_W)*INST_W-1:0] ROM_INIT = '0
) (
  input  logic              cph2,
  input  logic              pon,
  input  logic              sync,
  input  logic              ia,
  input  logic              lpmode,
  output logic              is,
  output logic              ws,
  output logic [PAGE_W-1:0] page_cur,
  output logic              page_err
);

  // Word timing, all in counter cycles.
  localparam logic [5:0] c_CNT_LAST  = 6'(4*DIGITS-1);
  localparam logic [5:0] c_CNT_STAT  = 6'd11;
  localparam logic [5:0] c_ADR_LO    = 6'd19;
  localparam logic [5:0] c_ADR_HI    = 6'(19+ADR_W-1);
  localparam logic [5:0] c_CNT_FETCH = 6'(19+ADR_W+1);
  localparam logic [5:0] c_OUT_LO    = 6'd45;
  localparam logic [5:0] c_OUT_HI    = 6'(45+INST_W-1);

  localparam logic [PAGE_W:0] c_NPAGES_P = (PAGE_W+1)'(N_PAGES);
  localparam logic [3:0]      c_NPAGES_4 = 4'(N_PAGES);

  localparam int c_IMG_W = N_PAGES * (2**ADR_W) * INST_W;
  localparam int c_LSB_W = $clog2(c_IMG_W);

  logic [5:0]        r_cnt;
  logic              r_sync_d;
  logic              r_run;       // a word has started since the last reset
  logic [ADR_W-1:0]  r_adr;
  logic [INST_W-1:0] r_inst;
  logic [2:0]        r_ws_buf;
  logic [PAGE_W-1:0] r_page;
  logic [PAGE_W-1:0] r_pend_page;
  logic              r_pend_v;
  logic              r_page_err;

  logic                    w_sync_fall;
  logic                    w_adr_win;
  logic                    w_out_win;
  logic [PAGE_W+ADR_W-1:0] w_rom_addr;
  logic                    w_page_ok;
  logic [c_LSB_W-1:0]      w_rom_lsb;
  logic [INST_W-1:0]       w_rom_word;
  logic [2:0]              w_sel_pg;
  logic                    w_sel_ok;
  logic                    w_imm;
  logic                    w_del;
  logic [3:0]              w_digit;
  logic                    w_ws;

  assign w_sync_fall = r_sync_d & ~sync;
  assign w_adr_win   = (r_cnt >= c_ADR_LO) && (r_cnt <= c_ADR_HI);
  assign w_out_win   = (r_cnt >= c_OUT_LO) && (r_cnt <= c_OUT_HI);

  // Array read. A page outside the array (not reachable through a legal
  // select) reads as zero instead of indexing past the image.
  assign w_rom_addr = {r_page, r_adr};
  assign w_page_ok  = {1'b0, r_page} < c_NPAGES_P;
  assign w_rom_lsb  = c_LSB_W'(32'(w_rom_addr) * INST_W);
  assign w_rom_word = w_page_ok ? ROM_INIT[w_rom_lsb +: INST_W] : '0;

  // Decode fields of the instruction held in r_inst. At cnt 55 it has been
  // rotated back to its fetched position.
  assign w_sel_pg = r_inst[9:7];
  assign w_sel_ok = {1'b0, w_sel_pg} < c_NPAGES_4;
  assign w_imm    = (r_inst[6:0] == 7'b0010000);
  assign w_del    = (r_inst[6:0] == 7'b1110100);

  always_ff @(posedge cph2) begin
    if (pon) begin
      r_cnt       <= '0;
      r_sync_d    <= 1'b0;
      r_run       <= 1'b0;
      r_adr       <= '0;
      r_inst      <= '0;
      r_ws_buf    <= '0;
      r_page      <= '0;
      r_pend_page <= '0;
      r_pend_v    <= 1'b0;
      r_page_err  <= 1'b0;
    end else begin
      r_sync_d <= sync;

      // A sync falling edge and the natural wrap both land on zero.
      if (w_sync_fall || (r_cnt == c_CNT_LAST)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 6'd1;
      end

      if (w_sync_fall) begin
        r_run <= 1'b1;
      end

      if (r_run) begin
        if (w_adr_win) begin
          r_adr <= {ia, r_adr[ADR_W-1:1]};
        end

        // The fetch and the output rotation never overlap in time. After
        // INST_W rotations, r_inst holds the fetched word again.
        if (r_cnt == c_CNT_FETCH) begin
          r_inst <= lpmode ? '0 : w_rom_word;
        end else if (w_out_win) begin
          r_inst <= {r_inst[0], r_inst[INST_W-1:1]};
        end

        if (r_cnt == c_CNT_LAST) begin
          if (w_imm) begin
            if (w_sel_ok) begin
              r_page   <= PAGE_W'(w_sel_pg);
              r_pend_v <= 1'b0;
            end else begin
              r_page_err <= 1'b1;
            end
          end else if (w_del) begin
            if (w_sel_ok) begin
              r_pend_page <= PAGE_W'(w_sel_pg);
              r_pend_v    <= 1'b1;
            end else begin
              r_page_err <= 1'b1;
            end
          end else if (r_pend_v) begin
            // The pending select was armed at an earlier word end. This
            // word was not a select, so the delayed switch lands now.
            r_page   <= r_pend_page;
            r_pend_v <= 1'b0;
          end

          r_ws_buf <= (r_inst[6:5] == 2'b10) ? r_inst[9:7] : 3'b000;
        end
      end
    end
  end

  // Word-select window: a pure function of registered state.
  assign w_digit = r_cnt[5:2];

  always_comb begin
    w_ws = 1'b0;
    case (r_ws_buf)
      3'b001:  w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd12);
      3'b010:  w_ws = (w_digit <= 4'd2);
      3'b011:  w_ws = 1'b1;
      3'b101:  w_ws = (w_digit >= 4'd3) && (w_digit <= 4'd13);
      3'b110:  w_ws = (w_digit == 4'd2);
      3'b111:  w_ws = (w_digit == 4'd13);
      default: w_ws = 1'b0;
    endcase
  end

  assign is       = r_run & ((r_cnt == c_CNT_STAT) | (w_out_win & r_inst[0]));
  assign ws       = w_ws;
  assign page_cur = r_page;
  assign page_err = r_page_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_rom_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_rom_bank
// Purpose  : Self-checking bench for serial_rom_bank. It runs a four-page
//            instance, plus a two-page instance for the illegal-page checks.
//            Each word comes from a table of records. The fetched
//            instruction is queued when the fetch stimulus is driven. It is
//            compared when its bits have been shifted out on is.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rom_bank;

  localparam int IMG4 = 4 * 256 * 10;

  // Reference array contents. Filler words have inst[6:5] = 01, so they are
  // neither selects nor word-select instructions.
  function automatic logic [9:0] rom_word(int a);
    logic [9:0] v;
    case (a)
      'h05A:   v = 10'h2B5;
      'h010:   v = 10'h090;   // immediate select page 1
      'h15A:   v = 10'h3A1;
      'h111:   v = 10'h010;   // immediate select page 0
      'h020:   v = 10'h174;   // delayed select page 2
      'h25A:   v = 10'h1A5;
      'h211:   v = 10'h010;
      'h030:   v = 10'h0C3;   // word select M
      'h040:   v = 10'h190;   // immediate select page 3
      'h35A:   v = 10'h2A7;
      'h331:   v = 10'h1C1;   // word select W
      default: begin
        v      = 10'((a * 37 + 5) & 'h3FF);
        v[6:5] = 2'b01;
      end
    endcase
    return v;
  endfunction

  function automatic logic [IMG4-1:0] build_img();
    logic [IMG4-1:0] img;
    img = '0;
    for (int a = 0; a < 1024; a++) img[a*10 +: 10] = rom_word(a);
    return img;
  endfunction

  localparam logic [IMG4-1:0]   C_IMG4 = build_img();
  localparam logic [IMG4/2-1:0] C_IMG2 = C_IMG4[IMG4/2-1:0];

  logic       clk = 1'b0;
  logic       pon = 1'b0;
  logic       sync = 1'b0;
  logic       ia = 1'b0;
  logic       lpmode = 1'b0;
  logic       is_a, ws_a, err_a, is_b, ws_b, err_b;
  logic [2:0] pg_a, pg_b;

  always #5 clk = ~clk;

  serial_rom_bank #(.N_PAGES(4), .ROM_INIT(C_IMG4)) u_dut (
    .cph2(clk), .pon(pon), .sync(sync), .ia(ia), .lpmode(lpmode),
    .is(is_a), .ws(ws_a), .page_cur(pg_a), .page_err(err_a)
  );

  serial_rom_bank #(.N_PAGES(2), .ROM_INIT(C_IMG2)) u_dut2 (
    .cph2(clk), .pon(pon), .sync(sync), .ia(ia), .lpmode(lpmode),
    .is(is_b), .ws(ws_b), .page_cur(pg_b), .page_err(err_b)
  );

  typedef struct packed {
    logic [7:0] adr;
    logic       lp;
    logic [9:0] inst;   // expected instruction on is
    logic [2:0] wsc;    // expected word-select code active in this word
    logic [2:0] page;   // expected page_cur after this word's decode
    logic       err;
    logic       chk2;   // also check the two-page instance
    logic [2:0] page2;
    logic       err2;
  } vec_t;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [9:0] sb[$];

  function automatic vec_t mk(int adr, int lp, int inst, int wsc, int page,
                              int err, int chk2, int page2, int err2);
    vec_t v;
    v.adr   = 8'(adr);
    v.lp    = 1'(lp);
    v.inst  = 10'(inst);
    v.wsc   = 3'(wsc);
    v.page  = 3'(page);
    v.err   = 1'(err);
    v.chk2  = 1'(chk2);
    v.page2 = 3'(page2);
    v.err2  = 1'(err2);
    return v;
  endfunction

  function automatic logic [55:0] exp_is(logic [9:0] inst);
    logic [55:0] v;
    v     = '0;
    v[11] = 1'b1;
    for (int i = 0; i < 10; i++) v[6'(45 + i)] = inst[4'(i)];
    return v;
  endfunction

  function automatic logic [55:0] exp_ws(logic [2:0] code);
    logic [55:0] v;
    int          d;
    v = '0;
    for (int c = 0; c < 56; c++) begin
      d = c / 4;
      case (code)
        3'd1:    v[6'(c)] = (d >= 3 && d <= 12);
        3'd2:    v[6'(c)] = (d <= 2);
        3'd3:    v[6'(c)] = 1'b1;
        3'd5:    v[6'(c)] = (d >= 3 && d <= 13);
        3'd6:    v[6'(c)] = (d == 2);
        3'd7:    v[6'(c)] = (d == 13);
        default: v[6'(c)] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs for the cycle in which the counter reads c. Outside their
  // windows, ia and lpmode carry random values that must have no effect.
  task automatic drive(input int c, input logic [7:0] adr, input logic lp);
    if (c >= 19 && c < 27) ia = adr[3'(c - 19)];
    else                   ia = 1'($urandom);
    lpmode = (c == 28) ? lp : 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pon = 1'b1; sync = 1'b0; ia = 1'b0; lpmode = 1'b0;
    @(posedge clk);
    #1;
    check("rst_is",   64'(is_a),  64'(0));
    check("rst_ws",   64'(ws_a),  64'(0));
    check("rst_page", 64'(pg_a),  64'(0));
    check("rst_err",  64'(err_a), 64'(0));
    check("rst_err2", 64'(err_b), 64'(0));
    @(negedge clk);
    pon = 1'b0;
  endtask

  // After this task returns, the counter is 0 at the start of a word.
  task automatic do_sync();
    @(negedge clk); sync = 1'b1;
    @(posedge clk);
    @(negedge clk); sync = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_word(input vec_t v, input int idx);
    logic [55:0] is_v, ws_v, win;
    logic [9:0]  want;
    is_v = '0;
    ws_v = '0;
    win  = 56'h3FF << 45;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      is_v[6'(c)] = is_a;
      ws_v[6'(c)] = ws_a;
      drive(c, v.adr, v.lp);
      if (c == 28) sb.push_back(v.inst);
      @(posedge clk);
    end
    #1;
    if (sb.size() == 0) begin
      check($sformatf("w%0d scoreboard_empty", idx), 64'(1), 64'(0));
    end else begin
      want = sb.pop_front();
      check($sformatf("w%0d is_data", idx), 64'(is_v[54:45]), 64'(want));
    end
    check($sformatf("w%0d is_frame", idx), 64'(is_v & ~win), 64'(56'h800));
    check($sformatf("w%0d ws", idx), 64'(ws_v), 64'(exp_ws(v.wsc)));
    check($sformatf("w%0d page", idx), 64'(pg_a), 64'(v.page));
    check($sformatf("w%0d err", idx), 64'(err_a), 64'(v.err));
    if (v.chk2) begin
      check($sformatf("w%0d page2", idx), 64'(pg_b), 64'(v.page2));
      check($sformatf("w%0d err2", idx), 64'(err_b), 64'(v.err2));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        tv[19];
    logic [55:0] is_v, ws_v, e_is, e_ws;
    int          idle_hits;

    //          adr   lp inst   ws pg er c2 p2 e2
    tv[0]  = mk('h5A, 0, 'h2B5, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk('h10, 0, 'h090, 0, 1, 0, 0, 0, 0);
    tv[2]  = mk('h5A, 0, 'h3A1, 0, 1, 0, 0, 0, 0);
    tv[3]  = mk('h11, 0, 'h010, 0, 0, 0, 0, 0, 0);
    tv[4]  = mk('h20, 0, 'h174, 0, 0, 0, 0, 0, 0);
    tv[5]  = mk('h5A, 0, 'h2B5, 0, 2, 0, 0, 0, 0);
    tv[6]  = mk('h5A, 0, 'h1A5, 0, 2, 0, 0, 0, 0);
    tv[7]  = mk('h11, 0, 'h010, 0, 0, 0, 0, 0, 0);
    tv[8]  = mk('h30, 0, 'h0C3, 0, 0, 0, 0, 0, 0);
    tv[9]  = mk('h5A, 0, 'h2B5, 1, 0, 0, 0, 0, 0);
    tv[10] = mk('h5A, 1, 'h000, 0, 0, 0, 0, 0, 0);
    tv[11] = mk('h20, 0, 'h174, 0, 0, 0, 0, 0, 0);
    tv[12] = mk('h10, 0, 'h090, 0, 1, 0, 0, 0, 0);
    tv[13] = mk('h5A, 0, 'h3A1, 0, 1, 0, 0, 0, 0);
    tv[14] = mk('h11, 0, 'h010, 0, 0, 0, 0, 0, 0);
    tv[15] = mk('h40, 0, 'h190, 0, 3, 0, 1, 0, 1);
    tv[16] = mk('h5A, 0, 'h2A7, 0, 3, 0, 1, 0, 1);
    tv[17] = mk('h31, 0, 'h1C1, 0, 3, 0, 1, 0, 1);
    tv[18] = mk('h5A, 0, 'h2B5, 0, 0, 0, 1, 0, 0);

    // Basic fetch, selects, word select and low-power fetch.
    do_reset();
    do_sync();
    for (int i = 0; i <= 14; i++) run_word(tv[i], i);

    // Illegal page on the two-page instance; the four-page one takes page 3.
    do_reset();
    do_sync();
    for (int i = 15; i <= 17; i++) run_word(tv[i], i);

    // Reset at cnt 50, mid-shift, while word select W is active.
    is_v = '0;
    ws_v = '0;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      is_v[6'(c)] = is_a;
      ws_v[6'(c)] = ws_a;
      if (c == 50) pon = 1'b1;
      else         drive(c, 8'h5A, 1'b0);
      @(posedge clk);
    end
    #1;
    e_is = exp_is(10'h2A7);
    e_ws = exp_ws(3'd3);
    check("abort_is_pre", 64'(is_v[50:0]), 64'(e_is[50:0]));
    check("abort_ws_pre", 64'(ws_v[50:0]), 64'(e_ws[50:0]));
    check("abort_is",     64'(is_a),  64'(0));
    check("abort_ws",     64'(ws_a),  64'(0));
    check("abort_page",   64'(pg_a),  64'(0));
    check("abort_err2",   64'(err_b), 64'(0));
    @(negedge clk);
    pon = 1'b0;

    // No sync falling edge yet, so nothing may appear on is or ws.
    idle_hits = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (is_a || ws_a) idle_hits++;
      ia     = 1'($urandom);
      lpmode = 1'($urandom);
    end
    check("idle_quiet", 64'(idle_hits), 64'(0));

    do_sync();
    run_word(tv[18], 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
